// File: rtl/memory_tank_scheduler_if.sv
// Request/response bundle between store control and the mercury-tank scheduler.
// The store control logic uses the master side; the scheduler uses the slave side.
interface memory_tank_scheduler_if #(
  parameter int WORD_BITS = 18,
  parameter int WORDS     = 32
);
  localparam int ADDR_W = $clog2(WORDS);
  localparam int DATA_W = 2 * WORD_BITS;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic              req_long;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_long, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_long, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata
  );
endinterface

// File: rtl/memory_tank_scheduler.sv
// Bit-serial sequencer for one EDSAC mercury tank: tracks the circulating position and
// splices or captures one short/long word per request. Optional CRT feed: MEMORY_TANK_MONITOR_EN.
module memory_tank_scheduler #(
  parameter int WORD_BITS = 18,
  parameter int WORDS     = 32
) (
  input  logic                     r2_clk,
  input  logic                     r2_rst_n,
  memory_tank_scheduler_if.slave   bus,
  input  logic                     tank_mob,
  output logic                     tank_mib,
  output logic [$clog2(WORDS)-1:0] pos_minor,
  output logic [4:0]               pos_digit,
  output logic                     monitor_bit,
  output logic                     monitor_sync
);

  localparam int ADDR_W = $clog2(WORDS);
  localparam int DATA_W = 2 * WORD_BITS;
  localparam int CNT_W  = $clog2(DATA_W);

  localparam logic [4:0]       DIGIT_LAST = 5'(WORD_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_SHORT  = CNT_W'(WORD_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_LONG   = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SLOT,
    XFER,
    DONE
  } state_t;

  state_t state, state_next;

  logic              op_write;
  logic              op_long;
  logic              op_err;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_next;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] minor_inc;
  logic              digit_wrap;
  logic              slot_next;
  logic              req_bad;

  assign digit_wrap = (pos_digit == DIGIT_LAST);
  assign minor_inc  = pos_minor + ADDR_W'(1);
  // True one cycle ahead of the target slot, so XFER starts exactly on digit 0.
  assign slot_next  = digit_wrap && (minor_inc == op_addr);
  assign req_bad    = bus.req_long && bus.req_addr[0];

  // One register serves both directions: writes shift data out of bit 0,
  // reads shift the emerging bit into the MSB.
  assign shreg_next = {(op_write ? 1'b0 : tank_mob), shreg[DATA_W-1:1]};

  always_ff @(posedge r2_clk or negedge r2_rst_n) begin
    if (!r2_rst_n) begin
      pos_digit <= '0;
      pos_minor <= '0;
    end else if (digit_wrap) begin
      pos_digit <= '0;
      pos_minor <= minor_inc;
    end else begin
      pos_digit <= pos_digit + 5'd1;
    end
  end

  always_ff @(posedge r2_clk or negedge r2_rst_n) begin
    if (!r2_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_err   = 1'b0;
    tank_mib      = tank_mob;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          state_next = req_bad ? DONE : WAIT_SLOT;
        end
      end
      WAIT_SLOT: begin
        if (slot_next) begin
          state_next = XFER;
        end
      end
      XFER: begin
        if (op_write) begin
          tank_mib = shreg[0];
        end
        if (cnt == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_err   = op_err;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge r2_clk or negedge r2_rst_n) begin
    if (!r2_rst_n) begin
      op_write      <= 1'b0;
      op_long       <= 1'b0;
      op_err        <= 1'b0;
      op_addr       <= '0;
      shreg         <= '0;
      cnt           <= '0;
      bus.rsp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            op_write <= bus.req_write;
            op_long  <= bus.req_long;
            op_err   <= req_bad;
            op_addr  <= bus.req_addr;
            shreg    <= bus.req_wdata;
          end
        end
        WAIT_SLOT: begin
          if (slot_next) begin
            cnt <= op_long ? CNT_LONG : CNT_SHORT;
          end
        end
        XFER: begin
          shreg <= shreg_next;
          cnt   <= cnt - CNT_W'(1);
          // A short read leaves its word in the upper half; realign it on the final bit.
          if ((cnt == '0) && !op_write) begin
            bus.rsp_rdata <= op_long ? shreg_next
                                     : {{WORD_BITS{1'b0}}, shreg_next[DATA_W-1:WORD_BITS]};
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEMORY_TANK_MONITOR_EN
  logic frame_start;

  assign frame_start = (pos_minor == '0) && (pos_digit == '0);

  always_ff @(posedge r2_clk or negedge r2_rst_n) begin
    if (!r2_rst_n) begin
      monitor_bit  <= 1'b0;
      monitor_sync <= 1'b0;
    end else begin
      monitor_bit  <= tank_mob;
      monitor_sync <= frame_start;
    end
  end
`else
  assign monitor_bit  = 1'b0;
  assign monitor_sync = 1'b0;
`endif

endmodule

// File: tb/tb_memory_tank_scheduler.sv
// Scoreboard bench for memory_tank_scheduler with a bit-accurate 576-position tank model.
module tb_memory_tank_scheduler;

  localparam int WB   = 18;
  localparam int NW   = 32;
  localparam int CIRC = WB * NW;

  logic       r2_clk   = 1'b0;
  logic       r2_rst_n = 1'b0;
  logic       tank_mob;
  logic       tank_mib;
  logic [4:0] pos_minor;
  logic [4:0] pos_digit;
  logic       monitor_bit;
  logic       monitor_sync;

  memory_tank_scheduler_if #(.WORD_BITS(WB), .WORDS(NW)) bus ();

  memory_tank_scheduler #(.WORD_BITS(WB), .WORDS(NW)) dut (
    .r2_clk       (r2_clk),
    .r2_rst_n     (r2_rst_n),
    .bus          (bus),
    .tank_mob     (tank_mob),
    .tank_mib     (tank_mib),
    .pos_minor    (pos_minor),
    .pos_digit    (pos_digit),
    .monitor_bit  (monitor_bit),
    .monitor_sync (monitor_sync)
  );

  always #5 r2_clk = ~r2_clk;

  typedef struct {
    logic        err;
    logic [35:0] rdata;
    int          due;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc;
  int          last_lat = -1;
  logic        line [CIRC];
  logic [WB-1:0] exp_words [NW];
  logic [35:0] last_rdata = '0;
  logic        mb_m, ms_m;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // Bench cycle count doubles as the position reference.
  always @(posedge r2_clk or negedge r2_rst_n) begin
    if (!r2_rst_n) cyc <= 0;
    else           cyc <= cyc + 1;
  end

  assign tank_mob = line[cyc % CIRC];
  always @(posedge r2_clk) line[cyc % CIRC] <= tank_mib;

  always @(posedge r2_clk or negedge r2_rst_n) begin
    if (!r2_rst_n) begin
      mb_m <= 1'b0;
      ms_m <= 1'b0;
    end else begin
      mb_m <= tank_mob;
      ms_m <= (cyc % CIRC == 0);
    end
  end

  always @(negedge r2_clk) begin
    if (r2_rst_n && bus.rsp_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("rsp_err", 64'(bus.rsp_err), 64'(mon_e.err));
        check_eq("rsp_rdata", 64'(bus.rsp_rdata), 64'(mon_e.rdata));
        check_eq("rsp_cycle", 64'(cyc), 64'(mon_e.due));
        last_lat = cyc - mon_e.acc;
      end
    end
  end

  task automatic check_tank();
    logic [WB-1:0] v;
    for (int w = 0; w < NW; w++) begin
      for (int d = 0; d < WB; d++) v[d] = line[w * WB + d];
      check_eq($sformatf("tank_word%0d", w), 64'(v), 64'(exp_words[w]));
    end
  endtask

  task automatic do_req(input logic wr, input logic lng, input int addr,
                        input logic [35:0] data, input int a_pos);
    exp_t e;
    int   n;
    int   delta;
    n = 0;
    @(negedge r2_clk);
    while (!(bus.req_ready && (a_pos < 0 || cyc % CIRC == a_pos))) begin
      @(negedge r2_clk);
      n++;
      if (n > 2 * CIRC) begin
        check_eq("req_ready_timeout", 64'd0, 64'd1);
        return;
      end
    end
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_long  = lng;
    bus.req_addr  = 5'(addr);
    bus.req_wdata = data;
    e.acc = cyc;
    if (lng && (addr % 2 == 1)) begin
      e.err   = 1'b1;
      e.due   = cyc + 1;
      e.rdata = last_rdata;
    end else begin
      e.err = 1'b0;
      delta = (addr * WB - (cyc + 2) % CIRC + CIRC) % CIRC;
      e.due = cyc + 2 + delta + (lng ? 2 * WB : WB);
      if (wr) begin
        exp_words[addr] = data[WB-1:0];
        if (lng) exp_words[addr + 1] = data[2*WB-1:WB];
      end else begin
        last_rdata = lng ? {exp_words[addr + 1], exp_words[addr]} : {18'h0, exp_words[addr]};
      end
      e.rdata = last_rdata;
    end
    exp_q.push_back(e);
    @(negedge r2_clk);
    bus.req_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 2 * CIRC) begin
      @(negedge r2_clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check_eq("rsp_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    logic        mb_exp, ms_exp;
    logic [35:0] d;
    int          sync_cnt;
    int          n;

    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_long  = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    for (int w = 0; w < NW; w++) begin
      exp_words[w] = 18'($urandom);
      for (int b = 0; b < WB; b++) line[w * WB + b] = exp_words[w][b];
    end

    repeat (2) @(negedge r2_clk);
    check_eq("rst_req_ready", 64'(bus.req_ready), 64'd1);
    check_eq("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_eq("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
    check_eq("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    check_eq("rst_pos_minor", 64'(pos_minor), 64'd0);
    check_eq("rst_pos_digit", 64'(pos_digit), 64'd0);
    check_eq("rst_monitor_bit", 64'(monitor_bit), 64'd0);
    check_eq("rst_monitor_sync", 64'(monitor_sync), 64'd0);
    check_eq("rst_recirc", 64'(tank_mib), 64'(tank_mob));
    r2_rst_n = 1'b1;

    sync_cnt = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge r2_clk);
`ifdef MEMORY_TANK_MONITOR_EN
      mb_exp = mb_m;
      ms_exp = ms_m;
`else
      mb_exp = 1'b0;
      ms_exp = 1'b0;
`endif
      check_eq("free_pos_digit", 64'(pos_digit), 64'(cyc % WB));
      check_eq("free_pos_minor", 64'(pos_minor), 64'((cyc / WB) % NW));
      check_eq("free_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check_eq("free_monitor_bit", 64'(monitor_bit), 64'(mb_exp));
      check_eq("free_monitor_sync", 64'(monitor_sync), 64'(ms_exp));
      if (monitor_sync) sync_cnt++;
    end
`ifdef MEMORY_TANK_MONITOR_EN
    check_eq("sync_pulses", 64'(sync_cnt), 64'd2);
`else
    check_eq("sync_pulses", 64'(sync_cnt), 64'd0);
`endif

    do_req(1'b1, 1'b0, 5, 36'h2A5A5, -1);
    do_req(1'b0, 1'b0, 5, 36'h0, -1);
    check_eq("read_addr5", 64'(bus.rsp_rdata), 64'h2A5A5);
    check_tank();

    do_req(1'b1, 1'b1, 30, 36'hF_0F0F_0F0F, -1);
    do_req(1'b0, 1'b1, 30, 36'h0, -1);
    check_eq("read_long30", 64'(bus.rsp_rdata), 64'hF_0F0F_0F0F);
    check_tank();

    do_req(1'b1, 1'b1, 7, 36'hF_FFFF_FFFF, -1);
    check_eq("err_latency", 64'(last_lat), 64'd1);
    check_eq("err_rdata_held", 64'(bus.rsp_rdata), 64'hF_0F0F_0F0F);
    check_tank();

    do_req(1'b0, 1'b0, 12, 36'h0, 12 * WB - 1);
    check_eq("lat_slot_missed", 64'(last_lat), 64'd595);
    do_req(1'b0, 1'b0, 12, 36'h0, 12 * WB - 2);
    check_eq("lat_slot_hit", 64'(last_lat), 64'd20);

    for (int i = 0; i < 8; i++) begin
      do_req(1'($urandom), 1'($urandom), int'($urandom_range(0, NW - 1)),
             {4'($urandom), 32'($urandom)}, -1);
    end
    check_tank();

    // Abort a short write to word 10 after digits 0..4 have gone into the line.
    d = 36'h15A3C;
    n = 0;
    @(negedge r2_clk);
    while (!(bus.req_ready && cyc % CIRC == 170) && n < 2 * CIRC) begin
      @(negedge r2_clk);
      n++;
    end
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_long  = 1'b0;
    bus.req_addr  = 5'd10;
    bus.req_wdata = d;
    @(negedge r2_clk);
    bus.req_valid = 1'b0;
    n = 0;
    while (cyc % CIRC != 185 && n < CIRC) begin
      @(negedge r2_clk);
      n++;
    end
    check_eq("xfer_mib_bit5", 64'(tank_mib), 64'(d[5]));
    #1 r2_rst_n = 1'b0;
    #1;
    check_eq("abort_req_ready", 64'(bus.req_ready), 64'd1);
    check_eq("abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_eq("abort_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    check_eq("abort_pos_digit", 64'(pos_digit), 64'd0);
    check_eq("abort_pos_minor", 64'(pos_minor), 64'd0);
    check_eq("abort_recirc", 64'(tank_mib), 64'(tank_mob));
    exp_words[10][4:0] = d[4:0];
    last_rdata = '0;
    repeat (2) @(negedge r2_clk);
    r2_rst_n = 1'b1;
    @(negedge r2_clk);
    check_eq("post_rst_ready", 64'(bus.req_ready), 64'd1);
    check_tank();

    do_req(1'b0, 1'b0, 10, 36'h0, -1);
    do_req(1'b1, 1'b1, 30, 36'h9_8765_4321, -1);
    do_req(1'b0, 1'b1, 30, 36'h0, -1);
    check_tank();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
